// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled pins, one-byte TX holding register,
// RX FIFO, W1C status flags and a registered interrupt.
`timescale 1ns/1ps
module spi_slave #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         RX_DEPTH_LOG2 = 2,
  parameter logic [7:0] FILL_BYTE     = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  we,
  input  logic        rd,
  input  logic        select,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_ss_n,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  localparam int DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int CW    = RX_DEPTH_LOG2 + 1;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ssn_sync;
  logic                   sclk_d;
  logic                   ssn_d;

  logic [7:0] shift_in;
  logic [7:0] shift_out;
  logic [2:0] bitcnt;
  logic       byte_done;
  logic [7:0] tx_hold;
  logic       tx_valid;
  logic       overrun;
  logic       underrun;
  logic       abort;
  logic [2:0] ctrl;

  logic [7:0]               mem [DEPTH];
  logic [RX_DEPTH_LOG2-1:0] wptr;
  logic [RX_DEPTH_LOG2-1:0] rptr;
  logic [CW-1:0]            count;

  logic sclk_s;
  logic mosi_s;
  logic ssn_s;
  logic ss_active;
  logic ss_fall;
  logic ss_rise;
  logic rise_ev;
  logic fall_ev;
  logic reload;
  logic [7:0] load_byte;
  logic push;
  logic full;
  logic empty;
  logic pop;
  logic do_push;
  logic overrun_set;
  logic underrun_set;
  logic abort_set;
  logic wr;
  logic wr_data;
  logic wr_stat;
  logic wr_ctrl;
  logic flush;
  logic [2:0] clr;
  logic [7:0] head;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ssn_s     = ssn_sync[SYNC_STAGES-1];
  assign ss_active = ~ssn_s;
  assign ss_fall   = ssn_d & ~ssn_s;
  assign ss_rise   = ~ssn_d & ssn_s;
  assign rise_ev   = ss_active & ~ss_fall & sclk_s & ~sclk_d;
  assign fall_ev   = ss_active & ~ss_fall & ~sclk_s & sclk_d;

  assign reload    = ss_fall | (fall_ev & byte_done);
  assign load_byte = tx_valid ? tx_hold : FILL_BYTE;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign head        = empty ? 8'h00 : mem[rptr];
  assign pop         = select & rd & (addr == 2'd0) & ~empty;
  assign push        = rise_ev & (bitcnt == 3'd7);
  assign do_push     = push & (~full | pop);
  assign overrun_set = push & full & ~pop;

  assign underrun_set = reload & ~tx_valid;
  assign abort_set    = ss_rise & (bitcnt != 3'd0);

  assign wr      = select & (|we);
  assign wr_data = wr & (addr == 2'd0) & we[0];
  assign wr_stat = wr & (addr == 2'd1) & we[0];
  assign wr_ctrl = wr & (addr == 2'd2);
  assign flush   = wr_ctrl & we[1] & wdata[8];
  assign clr     = wr_stat ? wdata[5:3] : 3'b000;

  assign spi_miso    = ss_active & shift_out[7];
  assign spi_miso_oe = ss_active;

  // Bring the asynchronous SPI pins into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ssn_sync  <= '1;
      sclk_d    <= 1'b0;
      ssn_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], spi_ss_n};
      sclk_d    <= sclk_s;
      ssn_d     <= ssn_s;
    end
  end

  // Bit engine: sample MOSI on rise, advance MISO on fall
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_in  <= '0;
      shift_out <= '0;
      bitcnt    <= '0;
      byte_done <= 1'b0;
    end else if (ss_fall) begin
      bitcnt    <= '0;
      byte_done <= 1'b0;
      shift_out <= load_byte;
    end else if (ss_rise) begin
      bitcnt    <= '0;
      byte_done <= 1'b0;
    end else if (rise_ev) begin
      shift_in <= {shift_in[6:0], mosi_s};
      bitcnt   <= bitcnt + 3'd1;
      if (bitcnt == 3'd7) byte_done <= 1'b1;
    end else if (fall_ev) begin
      if (byte_done) begin
        shift_out <= load_byte;
        byte_done <= 1'b0;
      end else begin
        shift_out <= {shift_out[6:0], 1'b0};
      end
    end
  end

  // TX holding register; a CPU write beats a same-cycle reload
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_hold  <= '0;
      tx_valid <= 1'b0;
    end else if (wr_data) begin
      tx_hold  <= wdata[7:0];
      tx_valid <= 1'b1;
    end else if (reload) begin
      tx_valid <= 1'b0;
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= {shift_in[6:0], mosi_s};
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a set wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;
    end else begin
      overrun  <= (overrun  & ~clr[0]) | overrun_set;
      underrun <= (underrun & ~clr[1]) | underrun_set;
      abort    <= (abort    & ~clr[2]) | abort_set;
    end
  end

  // Interrupt enables
  always_ff @(posedge clk) begin
    if (reset) ctrl <= '0;
    else if (wr_ctrl && we[0]) ctrl <= wdata[2:0];
  end

  // Registered interrupt level
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else irq <= (ctrl[0] & ~empty) | (ctrl[1] & ~tx_valid) |
                (ctrl[2] & (overrun | underrun | abort));
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      addr == 2'd0: rdata[7:0] = head;
      addr == 2'd1: begin
        rdata[0]       = ~empty;
        rdata[1]       = full;
        rdata[2]       = ~tx_valid;
        rdata[3]       = overrun;
        rdata[4]       = underrun;
        rdata[5]       = abort;
        rdata[6]       = ss_active;
        rdata[8 +: CW] = count;
      end
      addr == 2'd2: rdata[2:0] = ctrl;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: drives an SPI master model and the CPU bus,
// scoreboarding MISO bytes and received RX bytes.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  we = '0;
  logic        rd = 1'b0;
  logic        select = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_ss_n = 1'b1;
  logic        spi_miso;
  logic        spi_miso_oe;

  int checks = 0;
  int failures = 0;
  logic [7:0] miso_q[$];
  logic [7:0] rx_q[$];

  spi_slave dut (
    .clk(clk), .reset(reset), .we(we), .rd(rd),
    .select(select), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d,
                        input logic [3:0] w);
    @(posedge clk); #1;
    select = 1'b1; addr = a; wdata = d; we = w;
    @(posedge clk); #1;
    select = 1'b0; we = '0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, input bit do_pop,
                        output logic [31:0] d);
    @(posedge clk); #1;
    select = 1'b1; addr = a; rd = do_pop;
    #1 d = rdata;
    @(posedge clk); #1;
    select = 1'b0; rd = 1'b0;
  endtask

  task automatic ss_on();
    spi_ss_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic ss_off();
    wait_clk(HALF);
    spi_ss_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input int nbits,
                          input bit pop_last, output logic [7:0] mi,
                          output logic [31:0] popped);
    mi = '0;
    popped = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = mo[i];
      wait_clk(HALF);
      mi[i] = spi_miso;
      spi_clk = 1'b1;
      if (pop_last && i == 0) begin
        @(posedge clk);
        @(posedge clk); #1;
        select = 1'b1; addr = 2'd0; rd = 1'b1;
        #1 popped = rdata;
        @(posedge clk); #1;
        select = 1'b0; rd = 1'b0;
        wait_clk(HALF - 3);
      end else begin
        wait_clk(HALF);
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    checks++;
    if ({irq, spi_miso, spi_miso_oe} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=000",
               {irq, spi_miso, spi_miso_oe});
    end
    cpu_rd(2'd1, 1'b0, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL reset_status got=%h exp=%h", d, 32'h4);
    end
    cpu_rd(2'd0, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", d);
    end
    cpu_rd(2'd2, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_ctrl got=%h exp=0", d);
    end
  endtask

  task automatic test_basic();
    logic [7:0] mi;
    logic [7:0] e;
    logic [31:0] p;
    logic [31:0] d;
    cpu_wr(2'd0, 32'hA5, 4'h1);
    miso_q.push_back(8'hA5);
    rx_q.push_back(8'h3C);
    ss_on();
    spi_xfer(8'h3C, 8, 1'b0, mi, p);
    ss_off();
    e = miso_q.pop_front();
    checks++;
    if (mi !== e) begin
      failures++;
      $display("FAIL basic_miso got=%h exp=%h", mi, e);
    end
    cpu_rd(2'd1, 1'b0, d);
    checks++;
    if ((d & 32'h701) !== 32'h101) begin
      failures++;
      $display("FAIL basic_status got=%h exp=%h", d & 32'h701, 32'h101);
    end
    cpu_rd(2'd0, 1'b1, d);
    e = rx_q.pop_front();
    checks++;
    if (d !== {24'h0, e}) begin
      failures++;
      $display("FAIL basic_rx got=%h exp=%h", d, e);
    end
    cpu_rd(2'd1, 1'b0, d);
    checks++;
    if (d[10:8] !== 3'd0) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=0", d[10:8]);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    logic [7:0] e;
    logic [31:0] p;
    logic [31:0] d;
    cpu_wr(2'd1, 32'h38, 4'h1);
    ss_on();
    for (int k = 0; k < 2; k++) begin
      miso_q.push_back(8'hFF);
      rx_q.push_back(k == 0 ? 8'h12 : 8'h34);
      spi_xfer(k == 0 ? 8'h12 : 8'h34, 8, 1'b0, mi, p);
      e = miso_q.pop_front();
      checks++;
      if (mi !== e) begin
        failures++;
        $display("FAIL underrun_miso%0d got=%h exp=%h", k, mi, e);
      end
    end
    ss_off();
    cpu_rd(2'd1, 1'b0, d);
    checks++;
    if (d[4] !== 1'b1) begin
      failures++;
      $display("FAIL underrun_set got=%b exp=1", d[4]);
    end
    cpu_wr(2'd1, 32'h10, 4'h1);
    cpu_rd(2'd1, 1'b0, d);
    checks++;
    if (d[4] !== 1'b0) begin
      failures++;
      $display("FAIL underrun_clr got=%b exp=0", d[4]);
    end
    for (int k = 0; k < 2; k++) begin
      cpu_rd(2'd0, 1'b1, d);
      e = rx_q.pop_front();
      checks++;
      if (d !== {24'h0, e}) begin
        failures++;
        $display("FAIL underrun_rx%0d got=%h exp=%h", k, d, e);
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] mi;
    logic [7:0] e;
    logic [31:0] p;
    logic [31:0] d;
    ss_on();
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) rx_q.push_back(8'(b));
      spi_xfer(8'(b), 8, 1'b0, mi, p);
    end
    ss_off();
    cpu_rd(2'd1, 1'b0, d);
    checks++;
    if ((d & 32'h70A) !== 32'h40A) begin
      failures++;
      $display("FAIL overrun_status got=%h exp=%h", d & 32'h70A, 32'h40A);
    end
    for (int k = 0; k < 4; k++) begin
      cpu_rd(2'd0, 1'b1, d);
      e = rx_q.pop_front();
      checks++;
      if (d !== {24'h0, e}) begin
        failures++;
        $display("FAIL overrun_rx%0d got=%h exp=%h", k, d, e);
      end
    end
    cpu_wr(2'd1, 32'h38, 4'h1);
    ss_on();
    for (int b = 1; b <= 5; b++) begin
      rx_q.push_back(8'(b));
      spi_xfer(8'(b), 8, b == 5, mi, p);
    end
    ss_off();
    e = rx_q.pop_front();
    checks++;
    if (p !== {24'h0, e}) begin
      failures++;
      $display("FAIL pop_at_full got=%h exp=%h", p, e);
    end
    cpu_rd(2'd1, 1'b0, d);
    checks++;
    if ((d & 32'h70A) !== 32'h402) begin
      failures++;
      $display("FAIL pushpop_status got=%h exp=%h", d & 32'h70A, 32'h402);
    end
    for (int k = 0; k < 4; k++) begin
      cpu_rd(2'd0, 1'b1, d);
      e = rx_q.pop_front();
      checks++;
      if (d !== {24'h0, e}) begin
        failures++;
        $display("FAIL pushpop_rx%0d got=%h exp=%h", k, d, e);
      end
    end
    cpu_wr(2'd1, 32'h38, 4'h1);
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    logic [7:0] e;
    logic [31:0] p;
    logic [31:0] d;
    ss_on();
    spi_xfer(8'hE0, 3, 1'b0, mi, p);
    ss_off();
    checks++;
    if (spi_miso_oe !== 1'b0) begin
      failures++;
      $display("FAIL abort_oe got=%b exp=0", spi_miso_oe);
    end
    cpu_rd(2'd1, 1'b0, d);
    checks++;
    if ((d & 32'h720) !== 32'h020) begin
      failures++;
      $display("FAIL abort_status got=%h exp=%h", d & 32'h720, 32'h020);
    end
    cpu_wr(2'd1, 32'h38, 4'h1);
    rx_q.push_back(8'h81);
    ss_on();
    spi_xfer(8'h81, 8, 1'b0, mi, p);
    ss_off();
    cpu_rd(2'd0, 1'b1, d);
    e = rx_q.pop_front();
    checks++;
    if (d !== {24'h0, e}) begin
      failures++;
      $display("FAIL abort_next_rx got=%h exp=%h", d, e);
    end
    cpu_wr(2'd1, 32'h38, 4'h1);
  endtask

  task automatic test_irq();
    logic [7:0] mi;
    logic [7:0] e;
    logic [31:0] p;
    logic [31:0] d;
    cpu_wr(2'd2, 32'h1, 4'h1);
    wait_clk(2);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_empty got=%b exp=0", irq);
    end
    rx_q.push_back(8'h5A);
    ss_on();
    spi_xfer(8'h5A, 8, 1'b0, mi, p);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_rx got=%b exp=1", irq);
    end
    ss_off();
    cpu_rd(2'd0, 1'b1, d);
    e = rx_q.pop_front();
    checks++;
    if (d !== {24'h0, e}) begin
      failures++;
      $display("FAIL irq_rx_data got=%h exp=%h", d, e);
    end
    wait_clk(2);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_after_read got=%b exp=0", irq);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    logic [7:0] e;
    logic [31:0] p;
    logic [31:0] d;
    cpu_wr(2'd2, 32'h7, 4'h1);
    ss_on();
    spi_xfer(8'h11, 8, 1'b0, mi, p);
    spi_xfer(8'hF0, 4, 1'b0, mi, p);
    reset = 1'b1;
    wait_clk(2);
    checks++;
    if ({irq, spi_miso, spi_miso_oe} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_outs got=%b exp=000",
               {irq, spi_miso, spi_miso_oe});
    end
    addr = 2'd1;
    #1;
    checks++;
    if (rdata !== 32'h4) begin
      failures++;
      $display("FAIL rstmid_status got=%h exp=%h", rdata, 32'h4);
    end
    addr = 2'd2;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_ctrl got=%h exp=0", rdata);
    end
    spi_ss_n = 1'b1;
    spi_clk = 1'b0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    rx_q.push_back(8'h55);
    ss_on();
    spi_xfer(8'h55, 8, 1'b0, mi, p);
    ss_off();
    cpu_rd(2'd0, 1'b1, d);
    e = rx_q.pop_front();
    checks++;
    if (d !== {24'h0, e}) begin
      failures++;
      $display("FAIL rstmid_rx got=%h exp=%h", d, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_overrun();
    test_abort();
    test_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
